// File: rtl/ccff_bitstream_loader.sv
// Serialises valid/ready configuration words LSB-first onto a ccff chain for exactly CHAIN_LEN bits.
// First bit one cycle after accept; source stalls in LOAD (no shift), cfg_ready low while shifting/done.
module ccff_bitstream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 17,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              cfg_done,
    output logic              err_overrun,
    output logic              err_underrun,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              last_head;
    logic              accept;
    logic              restart;
    logic              shifting;
    logic              last_bit;
    logic              word_end;

    // The chain output only matters to observers outside this block.
    logic unused_tail;
    assign unused_tail = ccff_tail;

    assign shifting = (state == S_SHIFT);
    assign accept   = (state == S_LOAD) && cfg_valid;
    assign restart  = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_bit = shifting && (bit_count >= LAST_BIT);
    assign word_end = shifting && (bit_idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)         state_nxt = S_LOAD;
            S_LOAD:  if (cfg_valid)     state_nxt = S_SHIFT;
            S_SHIFT: if (last_bit)      state_nxt = S_DONE;
                     else if (word_end) state_nxt = S_LOAD;
            S_DONE:  if (start)         state_nxt = S_LOAD;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word capture and per-word bit position; leftover bits of the final word are simply dropped.
    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (accept) begin
            shreg   <= cfg_data;
            bit_idx <= '0;
        end else if (shifting) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            bit_count <= '0;
        end else if (restart) begin
            bit_count <= '0;
        end else if (shifting && (bit_count < FULL_CNT)) begin
            bit_count <= bit_count + CNT_W'(1);
        end
    end

    // Head keeps its last driven value outside SHIFT so the chain input never glitches.
    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            last_head <= 1'b0;
        end else if (shifting) begin
            last_head <= shreg[0];
        end
    end

    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else if (restart) begin
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            if ((state == S_DONE) && cfg_valid) begin
                err_overrun <= 1'b1;
            end
            if (start && ((state == S_LOAD) || shifting)) begin
                err_underrun <= 1'b1;
            end
        end
    end

    assign cfg_ready     = (state == S_LOAD);
    assign ccff_shift_en = shifting;
    assign ccff_head     = shifting ? shreg[0] : last_head;
    assign busy          = (state == S_LOAD) || shifting;
    assign cfg_done      = (state == S_DONE);

endmodule
